// File: rtl/shift_reg_seq_if.sv
// Bus bundle for shift_reg_seq: control/data inputs plus register state outputs.
interface shift_reg_seq_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned AW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] d;
  logic [2:0]       op;
  logic [AW-1:0]    amt;
  logic             start;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] nq;
  logic             ser_out;
  logic             busy;
  logic             done;

  modport master (
    output d, op, amt, start, ser_in,
    input  q, nq, ser_out, busy, done
  );

  modport slave (
    input  d, op, amt, start, ser_in,
    output q, nq, ser_out, busy, done
  );
endinterface

// File: rtl/shift_reg_seq.sv
// WIDTH-bit register with load/clear and multi-cycle shift/rotate, start/busy/done handshake.
// Optional macro ARITH_SHIFT_EN turns op 011 into an arithmetic right shift (else it is SHR).
module shift_reg_seq #(
  parameter int unsigned WIDTH = 8
) (
  input logic           clk,
  input logic           reset,
  shift_reg_seq_if.slave bus
);
  localparam int unsigned AW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b010;
  localparam logic [2:0] OP_SHL   = 3'b100;
  localparam logic [2:0] OP_ROL   = 3'b110;
  localparam logic [2:0] OP_ROR   = 3'b111;
`ifdef ARITH_SHIFT_EN
  localparam logic [2:0] OP_ASR   = 3'b011;
`endif

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic             so_r, so_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic [2:0]       op_r, op_n;
  logic [AW-1:0]    cnt, cnt_n;
  logic [AW-1:0]    amt_sat;
  logic [WIDTH-1:0] step_q;
  logic             step_so;

  assign amt_sat = (bus.amt > AW'(WIDTH)) ? AW'(WIDTH) : bus.amt;

  // One single-bit step of the latched shift/rotate op
  always_comb begin
    step_q  = q_r;
    step_so = so_r;
    case (op_r)
      OP_SHL: begin
        step_q  = {q_r[WIDTH-2:0], bus.ser_in};
        step_so = q_r[WIDTH-1];
      end
      OP_ROL: begin
        step_q  = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        step_so = q_r[WIDTH-1];
      end
      OP_ROR: begin
        step_q  = {q_r[0], q_r[WIDTH-1:1]};
        step_so = q_r[0];
      end
`ifdef ARITH_SHIFT_EN
      OP_ASR: begin
        step_q  = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        step_so = q_r[0];
      end
`endif
      default: begin
        step_q  = {bus.ser_in, q_r[WIDTH-1:1]};
        step_so = q_r[0];
      end
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_n = state;
    q_n     = q_r;
    so_n    = so_r;
    busy_n  = busy_r;
    done_n  = 1'b0;
    op_n    = op_r;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_NOP:   done_n = 1'b1;
            OP_LOAD: begin
              q_n    = bus.d;
              done_n = 1'b1;
            end
            OP_CLEAR: begin
              q_n    = '0;
              done_n = 1'b1;
            end
            default: begin
              if (amt_sat == '0) begin
                done_n = 1'b1;
              end else begin
                state_n = SHIFT;
                busy_n  = 1'b1;
                cnt_n   = amt_sat;
                op_n    = bus.op;
              end
            end
          endcase
        end
      end
      SHIFT: begin
        q_n   = step_q;
        so_n  = step_so;
        cnt_n = cnt - AW'(1);
        if (cnt == AW'(1)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      q_r    <= '0;
      so_r   <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      op_r   <= OP_NOP;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      q_r    <= q_n;
      so_r   <= so_n;
      busy_r <= busy_n;
      done_r <= done_n;
      op_r   <= op_n;
      cnt    <= cnt_n;
    end
  end

  assign bus.q       = q_r;
  assign bus.nq      = ~q_r;
  assign bus.ser_out = so_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule
